// File: rtl/sram_arb_pkg.sv
// Shared definitions for the 16x512 single-port SRAM arbiter.
`timescale 1ns/1ps
package sram_arb_pkg;

   // Macro geometry: sky130 OpenRAM 16x512 1RW
   localparam int ARB_DATA_WIDTH = 16;
   localparam int ARB_ADDR_WIDTH = 9;

   // Top-level sequencing: zero-clear sweep (optional) then normal arbitration
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   // Which requester owns the macro in the current cycle
   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_A    = 2'd1,
      REQ_B    = 2'd2
   } req_id_e;

endpackage

// File: rtl/sram_arb_prio.sv
// Grant decision between instruction fetch (A) and data (B), with a
// saturating starvation counter that lifts A above B after STARVE_LIMIT
// consecutive denied cycles.
`timescale 1ns/1ps
module sram_arb_prio
   import sram_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk0,
   input  logic rst_n,
   input  logic en,
   input  logic a_req,
   input  logic b_req,
   output logic a_gnt,
   output logic b_gnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_q;
   logic [3:0] starve_d;
   req_id_e    winner;

   // Pick the owner: B by default, A when alone or once it has waited long enough
   always_comb begin
      winner = REQ_NONE;
      if (en) begin
         if (a_req && (!b_req || (starve_q == LIMIT))) begin
            winner = REQ_A;
         end else if (b_req) begin
            winner = REQ_B;
         end
      end
   end

   assign a_gnt = (winner == REQ_A);
   assign b_gnt = (winner == REQ_B);

   // Count consecutive cycles A is waiting; any grant or dropped request restarts it
   always_comb begin
      starve_d = starve_q;
      if (!a_req || a_gnt) begin
         starve_d = '0;
      end else if (starve_q != LIMIT) begin
         starve_d = starve_q + 4'd1;
      end
   end

   // Starvation counter register
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/sram_arbiter_1rw_16_512.sv
// Two-port front end for the single-port 16x512 OpenRAM macro.
// Port A is read-only instruction fetch, port B is read/write data.
// Macro pins are driven combinationally from this cycle's grant; read data
// is a passthrough of dout0, qualified by a one-cycle rvalid tag.
// Build option SRAM_CLEAR_EN: after reset, sweep zeros into every word
// (busy=1, requests ignored) before the first grant.
`timescale 1ns/1ps
module sram_arbiter_1rw_16_512
   import sram_arb_pkg::*;
#(
   parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
   parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk0,
   input  logic                  rst_n,
   input  logic                  a_req,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  busy,
   output logic                  csb0,
   output logic                  web0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);

   logic                  rst_done_q;
   logic                  run;
   logic                  clearing;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic [1:0]            rtag_q;
   logic [1:0]            rtag_d;
   req_id_e               sel;

   // Low only until the first edge after reset, so no pin activity leaks into reset
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         rst_done_q <= 1'b0;
      end else begin
         rst_done_q <= 1'b1;
      end
   end

`ifdef SRAM_CLEAR_EN
   state_e                state_q;
   state_e                state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q;
   logic [ADDR_WIDTH-1:0] clr_addr_d;

   assign clearing = rst_done_q && (state_q == ST_CLEAR);
   assign run      = (state_q == ST_RUN);
   assign busy     = (state_q == ST_CLEAR);
   assign clr_addr = clr_addr_q;

   // Clear sweep: one word per cycle, leave for RUN after the top address
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      if (clearing) begin
         clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
         if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = ST_RUN;
         end
      end
   end

   // FSM state and clear address registers
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end
`else
   assign clearing = 1'b0;
   assign run      = rst_done_q;
   assign busy     = 1'b0;
   assign clr_addr = '0;
`endif

   sram_arb_prio #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clk0  (clk0),
      .rst_n (rst_n),
      .en    (run),
      .a_req (a_req),
      .b_req (b_req),
      .a_gnt (a_gnt),
      .b_gnt (b_gnt)
   );

   assign sel = a_gnt ? REQ_A : (b_gnt ? REQ_B : REQ_NONE);

   // Macro pin mux: clear sweep, granted A read, granted B access, or idle
   always_comb begin
      csb0  = 1'b1;
      web0  = 1'b1;
      addr0 = '0;
      din0  = '0;
      if (clearing) begin
         csb0  = 1'b0;
         web0  = 1'b0;
         addr0 = clr_addr;
      end else begin
         case (sel)
            REQ_A: begin
               csb0  = 1'b0;
               addr0 = a_addr;
            end
            REQ_B: begin
               csb0  = 1'b0;
               web0  = ~b_we;
               addr0 = b_addr;
               if (b_we) begin
                  din0 = b_wdata;
               end
            end
            default: ;
         endcase
      end
   end

   // One-hot read tag: bit 0 = A read, bit 1 = B read; writes leave no tag
   always_comb begin
      rtag_d = {b_gnt & ~b_we, a_gnt};
   end

   // Read tag register, dropped on reset
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         rtag_q <= '0;
      end else begin
         rtag_q <= rtag_d;
      end
   end

   assign a_rvalid = rtag_q[0];
   assign b_rvalid = rtag_q[1];
   assign a_rdata  = dout0;
   assign b_rdata  = dout0;

endmodule

// File: tb/tb_sram_arbiter_1rw_16_512.sv
// Bench for sram_arbiter_1rw_16_512 with a behavioural 1RW macro model and a
// rule-level reference model of arbitration, read latency and memory contents.
`timescale 1ns/1ps
module tb_sram_arbiter_1rw_16_512;

   localparam int LIMIT = 4;

   logic        clk0;
   logic        rst_n;
   logic        a_req;
   logic [8:0]  a_addr;
   logic        a_gnt;
   logic        a_rvalid;
   logic [15:0] a_rdata;
   logic        b_req;
   logic        b_we;
   logic [8:0]  b_addr;
   logic [15:0] b_wdata;
   logic        b_gnt;
   logic        b_rvalid;
   logic [15:0] b_rdata;
   logic        busy;
   logic        csb0;
   logic        web0;
   logic [8:0]  addr0;
   logic [15:0] din0;
   logic [15:0] dout0;

   int n_cmp;
   int n_bad;

   sram_arbiter_1rw_16_512 #(
      .DATA_WIDTH   (16),
      .ADDR_WIDTH   (9),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk0     (clk0),
      .rst_n    (rst_n),
      .a_req    (a_req),
      .a_addr   (a_addr),
      .a_gnt    (a_gnt),
      .a_rvalid (a_rvalid),
      .a_rdata  (a_rdata),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_gnt    (b_gnt),
      .b_rvalid (b_rvalid),
      .b_rdata  (b_rdata),
      .busy     (busy),
      .csb0     (csb0),
      .web0     (web0),
      .addr0    (addr0),
      .din0     (din0),
      .dout0    (dout0)
   );

   initial clk0 = 1'b0;
   always #5 clk0 = ~clk0;

   // Behavioural macro: capture on posedge, access on negedge
   logic [15:0] mem [512];
   logic        cap_v;
   logic        cap_we;
   logic [8:0]  cap_a;
   logic [15:0] cap_d;
   initial begin
      cap_v = 1'b0;
      dout0 = 16'h0;
   end
   always @(posedge clk0) begin
      cap_v  = !csb0;
      cap_we = !web0;
      cap_a  = addr0;
      cap_d  = din0;
   end
   always @(negedge clk0) begin
      if (cap_v) begin
         if (cap_we) mem[cap_a] = cap_d;
         else dout0 = mem[cap_a];
      end
   end

   // Reference model state
   logic [15:0] mem_ref [512];
   int          m_starve;
   int          m_clear_left;
   logic        pend_a, pend_b;
   logic [15:0] pend_data;

   // Observed and expected values for the latest cycle
   logic        obs_a_gnt, obs_b_gnt, obs_a_rvalid, obs_b_rvalid, obs_busy, obs_csb0, obs_web0;
   logic [15:0] obs_a_rdata, obs_b_rdata, obs_din0;
   logic [8:0]  obs_addr0;
   logic        exp_a_gnt, exp_b_gnt, exp_a_rvalid, exp_b_rvalid, exp_busy, exp_csb0, exp_web0;
   logic [15:0] exp_rdata, exp_din0;
   logic [8:0]  exp_addr0;

   task automatic do_reset();
      a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
      a_addr = '0; b_addr = '0; b_wdata = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk0);
      #1 rst_n = 1'b1;
      m_starve = 0;
      pend_a = 1'b0;
      pend_b = 1'b0;
      pend_data = '0;
`ifdef SRAM_CLEAR_EN
      m_clear_left = 512;
`else
      m_clear_left = 0;
`endif
   endtask

   // Drive one cycle, sample after the negedge, and advance the model
   task automatic drive_cycle(input logic ar, input logic [8:0] aa, input logic br,
                              input logic bw, input logic [8:0] ba, input logic [15:0] bd);
      logic is_clear;
      int   clr_idx;
      @(posedge clk0);
      #1;
      a_req = ar; a_addr = aa; b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
      #7;
      obs_a_gnt = a_gnt; obs_b_gnt = b_gnt; obs_a_rvalid = a_rvalid; obs_b_rvalid = b_rvalid;
      obs_a_rdata = a_rdata; obs_b_rdata = b_rdata; obs_busy = busy;
      obs_csb0 = csb0; obs_web0 = web0; obs_addr0 = addr0; obs_din0 = din0;
      is_clear = (m_clear_left > 0);
      clr_idx  = 512 - m_clear_left;
      if (is_clear) m_clear_left--;
      exp_busy     = is_clear;
      exp_a_rvalid = pend_a;
      exp_b_rvalid = pend_b;
      exp_rdata    = pend_data;
      exp_a_gnt = !is_clear && ar && (!br || (m_starve == LIMIT));
      exp_b_gnt = !is_clear && br && !exp_a_gnt;
      if (!ar || exp_a_gnt) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      exp_csb0  = !(is_clear || exp_a_gnt || exp_b_gnt);
      exp_web0  = !(is_clear || (exp_b_gnt && bw));
      exp_addr0 = is_clear ? 9'(clr_idx) : (exp_a_gnt ? aa : ba);
      exp_din0  = is_clear ? 16'h0 : bd;
      pend_a    = exp_a_gnt;
      pend_b    = exp_b_gnt && !bw;
      pend_data = exp_a_gnt ? mem_ref[aa] : mem_ref[ba];
      if (is_clear) mem_ref[9'(clr_idx)] = 16'h0;
      if (exp_b_gnt && bw) mem_ref[ba] = bd;
   endtask

   task automatic test_reset();
      a_req = 1'b1; b_req = 1'b1; b_we = 1'b1;
      a_addr = 9'h003; b_addr = 9'h004; b_wdata = 16'h1234;
      rst_n = 1'b0;
      @(posedge clk0);
      #2;
      n_cmp++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_outputs gnt/rvalid got %b want 0000", {a_gnt, b_gnt, a_rvalid, b_rvalid});
      end
      n_cmp++;
      if ({csb0, web0, addr0, din0} !== {1'b1, 1'b1, 9'h0, 16'h0}) begin
         n_bad++;
         $display("FAIL reset_pins csb0=%b web0=%b addr0=%h din0=%h want 1 1 0 0", csb0, web0, addr0, din0);
      end
      n_cmp++;
`ifdef SRAM_CLEAR_EN
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_busy got %b want 1", busy);
      end
`else
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
`endif
      do_reset();
   endtask

`ifdef SRAM_CLEAR_EN
   task automatic test_clear();
      for (int i = 0; i < 512; i++) begin
         drive_cycle(1'($urandom), 9'($urandom), 1'($urandom), 1'($urandom), 9'($urandom), 16'($urandom));
         n_cmp++;
         if ({obs_busy, obs_csb0, obs_web0, obs_addr0, obs_din0, obs_a_gnt, obs_b_gnt}
             !== {1'b1, 1'b0, 1'b0, 9'(i), 16'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL clear_sweep cycle %0d busy=%b csb0=%b web0=%b addr0=%h din0=%h gnt=%b%b want busy=1 write of 0 at %h",
                     i, obs_busy, obs_csb0, obs_web0, obs_addr0, obs_din0, obs_a_gnt, obs_b_gnt, 9'(i));
         end
      end
      drive_cycle(1'b1, 9'h1FF, 1'b0, 1'b0, 9'h0, 16'h0);
      n_cmp++;
      if ({obs_busy, obs_a_gnt} !== 2'b01) begin
         n_bad++;
         $display("FAIL clear_done busy=%b a_gnt=%b want busy=0 a_gnt=1", obs_busy, obs_a_gnt);
      end
      drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
      n_cmp++;
      if ({obs_a_rvalid, obs_a_rdata} !== {1'b1, 16'h0000}) begin
         n_bad++;
         $display("FAIL clear_read_1ff rvalid=%b rdata=%h want 1 0000", obs_a_rvalid, obs_a_rdata);
      end
   endtask
`else
   task automatic test_no_clear();
      drive_cycle(1'b1, 9'h1FF, 1'b0, 1'b0, 9'h0, 16'h0);
      n_cmp++;
      if ({obs_busy, obs_a_gnt, obs_csb0} !== 3'b010) begin
         n_bad++;
         $display("FAIL first_cycle_run busy=%b a_gnt=%b csb0=%b want 0 1 0", obs_busy, obs_a_gnt, obs_csb0);
      end
      drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
      n_cmp++;
      if ({obs_a_rvalid, obs_a_rdata} !== {1'b1, exp_rdata}) begin
         n_bad++;
         $display("FAIL first_read rvalid=%b rdata=%h want 1 %h", obs_a_rvalid, obs_a_rdata, exp_rdata);
      end
   endtask
`endif

   task automatic test_idle();
      drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b0, 9'($urandom), 1'b0, 1'($urandom), 9'($urandom), 16'($urandom));
         n_cmp++;
         if ({obs_csb0, obs_web0, obs_a_rvalid, obs_b_rvalid, obs_a_gnt, obs_b_gnt} !== 6'b110000) begin
            n_bad++;
            $display("FAIL idle cycle %0d csb0=%b web0=%b rvalid=%b%b gnt=%b%b want 1 1 00 00",
                     i, obs_csb0, obs_web0, obs_a_rvalid, obs_b_rvalid, obs_a_gnt, obs_b_gnt);
         end
      end
   endtask

   task automatic test_write_read();
      drive_cycle(1'b0, 9'h0, 1'b1, 1'b1, 9'h005, 16'hBEEF);
      n_cmp++;
      if ({obs_b_gnt, obs_csb0, obs_web0, obs_addr0, obs_din0} !== {1'b1, 1'b0, 1'b0, 9'h005, 16'hBEEF}) begin
         n_bad++;
         $display("FAIL b_write_pins gnt=%b csb0=%b web0=%b addr0=%h din0=%h want 1 0 0 005 beef",
                  obs_b_gnt, obs_csb0, obs_web0, obs_addr0, obs_din0);
      end
      drive_cycle(1'b0, 9'h0, 1'b1, 1'b0, 9'h005, 16'h0);
      n_cmp++;
      if ({obs_b_gnt, obs_csb0, obs_web0, obs_addr0, obs_b_rvalid} !== {1'b1, 1'b0, 1'b1, 9'h005, 1'b0}) begin
         n_bad++;
         $display("FAIL b_read_pins gnt=%b csb0=%b web0=%b addr0=%h rvalid=%b want 1 0 1 005 0",
                  obs_b_gnt, obs_csb0, obs_web0, obs_addr0, obs_b_rvalid);
      end
      drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
      n_cmp++;
      if ({obs_b_rvalid, obs_a_rvalid, obs_b_rdata} !== {1'b1, 1'b0, 16'hBEEF}) begin
         n_bad++;
         $display("FAIL raw_same_addr b_rvalid=%b a_rvalid=%b b_rdata=%h want 1 0 beef",
                  obs_b_rvalid, obs_a_rvalid, obs_b_rdata);
      end
      drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
      n_cmp++;
      if (obs_b_rvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL b_rvalid_single got %b want 0", obs_b_rvalid);
      end
   endtask

   task automatic test_a_stream();
      logic [15:0] vals [3];
      for (int i = 0; i < 3; i++) begin
         vals[i] = 16'($urandom);
         drive_cycle(1'b0, 9'h0, 1'b1, 1'b1, 9'(9'h010 + i), vals[i]);
      end
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drive_cycle(1'b1, 9'(9'h010 + i), 1'b0, 1'b0, 9'h0, 16'h0);
         else drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
         n_cmp++;
         if ({obs_a_gnt, obs_a_rvalid} !== {1'(i < 3), 1'(i >= 1 && i <= 3)}) begin
            n_bad++;
            $display("FAIL a_stream cycle %0d gnt=%b rvalid=%b want %b %b",
                     i, obs_a_gnt, obs_a_rvalid, 1'(i < 3), 1'(i >= 1 && i <= 3));
         end
         if (i >= 1 && i <= 3) begin
            n_cmp++;
            if (obs_a_rdata !== vals[i-1]) begin
               n_bad++;
               $display("FAIL a_stream_data cycle %0d rdata=%h want %h", i, obs_a_rdata, vals[i-1]);
            end
         end
      end
   endtask

   task automatic test_starve();
      logic want_a;
      logic prev_a;
      drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
      for (int i = 0; i < 16; i++) begin
         drive_cycle(1'b1, 9'h020, 1'b1, 1'b0, 9'h030, 16'h0);
         want_a = ((i % 5) == 4);
         prev_a = (i > 0) && (((i - 1) % 5) == 4);
         n_cmp++;
         if ({obs_a_gnt, obs_b_gnt} !== {want_a, !want_a}) begin
            n_bad++;
            $display("FAIL starve_pattern cycle %0d gnt a/b=%b%b want %b%b", i, obs_a_gnt, obs_b_gnt, want_a, !want_a);
         end
         n_cmp++;
         if ({obs_a_rvalid, obs_b_rvalid} !== {prev_a, 1'(i > 0) & !prev_a}) begin
            n_bad++;
            $display("FAIL starve_rvalid cycle %0d rvalid a/b=%b%b want %b%b",
                     i, obs_a_rvalid, obs_b_rvalid, prev_a, 1'(i > 0) & !prev_a);
         end
         if (i > 0) begin
            n_cmp++;
            if (obs_a_rdata !== exp_rdata) begin
               n_bad++;
               $display("FAIL starve_data cycle %0d rdata=%h want %h", i, obs_a_rdata, exp_rdata);
            end
         end
      end
      drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
   endtask

   task automatic test_random();
      logic        ar, br, bw;
      logic [8:0]  aa, ba;
      logic [15:0] bd;
      ar = 1'b0; br = 1'b0; bw = 1'b0; aa = '0; ba = '0; bd = '0;
      for (int i = 0; i < 400; i++) begin
         if (!ar) begin
            ar = ($urandom_range(0, 2) != 0);
            aa = 9'($urandom_range(0, 15));
         end
         if (!br) begin
            br = ($urandom_range(0, 2) != 0);
            bw = 1'($urandom);
            ba = 9'($urandom_range(0, 15));
            bd = 16'($urandom);
         end
         drive_cycle(ar, aa, br, bw, ba, bd);
         n_cmp++;
         if ({obs_a_gnt, obs_b_gnt, obs_a_rvalid, obs_b_rvalid, obs_csb0, obs_web0, obs_busy}
             !== {exp_a_gnt, exp_b_gnt, exp_a_rvalid, exp_b_rvalid, exp_csb0, exp_web0, exp_busy}) begin
            n_bad++;
            $display("FAIL rand_ctrl cycle %0d gnt=%b%b rv=%b%b csb0=%b web0=%b busy=%b want %b%b %b%b %b %b %b",
                     i, obs_a_gnt, obs_b_gnt, obs_a_rvalid, obs_b_rvalid, obs_csb0, obs_web0, obs_busy,
                     exp_a_gnt, exp_b_gnt, exp_a_rvalid, exp_b_rvalid, exp_csb0, exp_web0, exp_busy);
         end
         if (exp_a_rvalid || exp_b_rvalid) begin
            n_cmp++;
            if ((exp_a_rvalid ? obs_a_rdata : obs_b_rdata) !== exp_rdata) begin
               n_bad++;
               $display("FAIL rand_rdata cycle %0d got %h want %h", i,
                        exp_a_rvalid ? obs_a_rdata : obs_b_rdata, exp_rdata);
            end
         end
         if (!exp_csb0) begin
            n_cmp++;
            if (obs_addr0 !== exp_addr0) begin
               n_bad++;
               $display("FAIL rand_addr0 cycle %0d got %h want %h", i, obs_addr0, exp_addr0);
            end
         end
         if (!exp_web0) begin
            n_cmp++;
            if (obs_din0 !== exp_din0) begin
               n_bad++;
               $display("FAIL rand_din0 cycle %0d got %h want %h", i, obs_din0, exp_din0);
            end
         end
         if (exp_a_gnt) ar = 1'b0;
         if (exp_b_gnt) br = 1'b0;
      end
      drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
   endtask

   task automatic test_reset_mid();
      drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
      drive_cycle(1'b1, 9'h011, 1'b0, 1'b0, 9'h0, 16'h0);
      n_cmp++;
      if (obs_a_gnt !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_reset_grant a_gnt=%b want 1", obs_a_gnt);
      end
      @(posedge clk0);
      #1;
      n_cmp++;
      if (a_rvalid !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_reset_pre a_rvalid=%b want 1", a_rvalid);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({a_rvalid, b_rvalid, a_gnt, b_gnt, csb0, web0} !== 6'b000011) begin
         n_bad++;
         $display("FAIL mid_reset_async rvalid=%b%b gnt=%b%b csb0=%b web0=%b want 00 00 1 1",
                  a_rvalid, b_rvalid, a_gnt, b_gnt, csb0, web0);
      end
      do_reset();
`ifdef SRAM_CLEAR_EN
      repeat (512) drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
`endif
      drive_cycle(1'b1, 9'h011, 1'b0, 1'b0, 9'h0, 16'h0);
      n_cmp++;
      if ({obs_busy, obs_a_gnt} !== 2'b01) begin
         n_bad++;
         $display("FAIL post_reset_grant busy=%b a_gnt=%b want 0 1", obs_busy, obs_a_gnt);
      end
      drive_cycle(1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 16'h0);
      n_cmp++;
      if ({obs_a_rvalid, obs_a_rdata} !== {1'b1, exp_rdata}) begin
         n_bad++;
         $display("FAIL post_reset_read rvalid=%b rdata=%h want 1 %h", obs_a_rvalid, obs_a_rdata, exp_rdata);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation exceeded time bound");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 512; i++) begin
         mem[i]     = 16'($urandom);
         mem_ref[i] = mem[i];
      end
      test_reset();
`ifdef SRAM_CLEAR_EN
      test_clear();
`else
      test_no_clear();
`endif
      test_idle();
      test_write_read();
      test_a_stream();
      test_starve();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_arbiter_1rw_16_512.md
Name: sram_arbiter_1rw_16_512

Overview:
- Shares the single-port 16x512 OpenRAM macro (1RW: inputs captured on posedge clk0, read/write on negedge) between two requesters.
- Port A is instruction fetch (read-only); port B is processor data (read/write).
- Sits between the Leros core and the macro and drives the macro pins csb0/web0/addr0/din0 directly.
- Optionally zero-clears the memory after reset before granting any access.

Parameters:
- DATA_WIDTH, 16, word width; must match the macro.
- ADDR_WIDTH, 9, word address width; depth = 1<<ADDR_WIDTH.
- STARVE_LIMIT, 4, consecutive cycles port A may be denied before it gets priority; range 1..15.

Ports:
- clk0  in  1  clock, shared with the macro.
- rst_n  in  1  asynchronous reset, active-low.
- a_req  in  1  port A read request.
- a_addr  in  ADDR_WIDTH  port A address.
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  a_rdata valid this cycle.
- a_rdata  out  DATA_WIDTH  port A read data.
- b_req  in  1  port B request.
- b_we  in  1  port B write (1) / read (0).
- b_addr  in  ADDR_WIDTH  port B address.
- b_wdata  in  DATA_WIDTH  port B write data.
- b_gnt  out  1  port B request accepted this cycle.
- b_rvalid  out  1  b_rdata valid this cycle.
- b_rdata  out  DATA_WIDTH  port B read data.
- busy  out  1  clear sequence in progress.
- csb0  out  1  macro chip select, active-low.
- web0  out  1  macro write enable, active-low.
- addr0  out  ADDR_WIDTH  macro address.
- din0  out  DATA_WIDTH  macro write data.
- dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Clock and reset: single clock, clk0. rst_n is asynchronous, active-low.
- Reset values: a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, busy=0 (1 if SRAM_CLEAR_EN), starvation counter=0, clear address=0.
- Macro pins during reset: csb0=1, web0=1. addr0 and din0 are don't-care but driven 0.
- States:
  - CLEAR: only when SRAM_CLEAR_EN is defined.
  - RUN.
  - Reset enters CLEAR if enabled, otherwise RUN.
- Macro pins are combinational from the grant decision in the current cycle; the macro captures them at the closing posedge.
- A request is accepted when req and gnt are both high in the same cycle. gnt is combinational from req, priority and state. Requesters hold address/data until granted.
- Arbitration in RUN:
  - B has priority by default.
  - If a_req=1 and b_req=0, grant A.
  - If both request and starve_cnt == STARVE_LIMIT, grant A; otherwise grant B.
  - At most one grant per cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle a_req=1 and a is not granted.
  - Clears when A is granted, or when a_req=0.
- Macro pin values:
  - Granted read: csb0=0, web0=1, addr0=addr.
  - Granted B write: csb0=0, web0=0, addr0=b_addr, din0=b_wdata.
  - No grant: csb0=1, web0=1.
- Read latency is 1 cycle:
  - A read granted in cycle N asserts x_rvalid for exactly cycle N+1.
  - x_rdata = dout0 (passthrough, valid after the negedge of N+1, sampled at the posedge ending N+1).
  - A registered one-hot tag selects which rvalid fires.
  - Writes produce no rvalid.
  - Back-to-back grants are allowed every cycle; rvalid for each port can be high on consecutive cycles.
- rdata is held: outside rvalid, x_rdata is undefined to the requester. The implementation passes dout0 through unconditionally.
- Same-address write then read in consecutive cycles: the read returns the new data, because the macro writes on the negedge before the read.
- Reset mid-operation: a pending rvalid is dropped. A write granted in the cycle reset asserts may or may not land; this is unspecified.
- busy mirrors the CLEAR state; a_gnt=b_gnt=0 while busy.

Optional Feature:
- Macro: SRAM_CLEAR_EN.
- Defined:
  - After reset, the FSM enters CLEAR and writes 0 to addresses 0..(1<<ADDR_WIDTH)-1, one per cycle (csb0=0, web0=0, din0=0, addr0=clear counter).
  - After the last address it moves to RUN.
  - Duration is exactly 512 cycles with busy=1. Requests are ignored (not queued) during CLEAR.
- Undefined: no CLEAR state and no clear counter; busy is tied 0; RUN from the first cycle after reset.

Decomposition:
- Shared package sram_arb_pkg: DATA_WIDTH/ADDR_WIDTH constants, state enum {ST_CLEAR, ST_RUN}, requester-id encoding {REQ_NONE, REQ_A, REQ_B}.
- One natural sub-module: sram_arb_prio, a combinational grant decision plus the saturating starvation counter. The top level holds the FSM, the clear counter, the rvalid tag pipeline and pin muxing.

Test Plan:
- SRAM_CLEAR_EN defined, reset released → busy=1 for 512 cycles with web0=0 and addr0 sweeping 0..511; a subsequent A read of 0x1FF returns 0x0000.
- B write addr 0x005 data 0xBEEF in cycle N, B read 0x005 in cycle N+1 → b_rvalid=1 in cycle N+2 with b_rdata=0xBEEF; a_rvalid stays 0.
- Both requesting every cycle, STARVE_LIMIT=4 → grant pattern B,B,B,B,A repeating; each A grant yields a_rvalid on the following cycle only.
- Only A requesting, addresses 0x010,0x011,0x012 on consecutive cycles → a_gnt high 3 cycles; a_rvalid high 3 cycles, lagging by 1 with the matching data.
- rst_n pulsed low during the cycle after an A read grant → a_rvalid=0 immediately (asynchronous), csb0=1 while rst_n=0.
- No requests → csb0=1, web0=1 every cycle; no rvalid.
